// File: rtl/lda_cmd_slave_if.sv
// Bus bundle between the CPU-facing Avalon-MM port and the LDA start/done link.
// The slave modport is the command front end; the master modport is the CPU/LDA side.
interface lda_cmd_slave_if #(
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int COLOR_W = 3
);
    logic [2:0]         i_avs_address;
    logic               i_avs_read;
    logic               i_avs_write;
    logic [31:0]        i_avs_writedata;
    logic [31:0]        o_avs_readdata;
    logic               o_avs_waitrequest;
    logic               o_start;
    logic [X_W-1:0]     o_x0;
    logic [Y_W-1:0]     o_y0;
    logic [X_W-1:0]     o_x1;
    logic [Y_W-1:0]     o_y1;
    logic [COLOR_W-1:0] o_color;
    logic               i_done;
    logic               o_busy;

    modport slave (
        input  i_avs_address, i_avs_read, i_avs_write, i_avs_writedata, i_done,
        output o_avs_readdata, o_avs_waitrequest, o_start,
               o_x0, o_y0, o_x1, o_y1, o_color, o_busy
    );

    modport master (
        output i_avs_address, i_avs_read, i_avs_write, i_avs_writedata, i_done,
        input  o_avs_readdata, o_avs_waitrequest, o_start,
               o_x0, o_y0, o_x1, o_y1, o_color, o_busy
    );
endinterface

// File: rtl/lda_cmd_slave.sv
// Avalon-MM command front end for the line-drawing accelerator: holds endpoints and
// colour, launches a line, and reports completion by stalling GO or via STATUS polling.
module lda_cmd_slave #(
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int COLOR_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    lda_cmd_slave_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_BUSY    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t              state_r, state_nxt_s;
    logic                mode_r, stall_op_r, start_r, busy_r;
    logic [X_W-1:0]      start_x_r, end_x_r, act_x0_r, act_x1_r;
    logic [Y_W-1:0]      start_y_r, end_y_r, act_y0_r, act_y1_r;
    logic [COLOR_W-1:0]  color_r, act_color_r;
    logic [CNT_W-1:0]    lines_r;
    logic [31:0]         rdata_s;
    logic                wait_s, go_wr_s, wr_acc_s, launch_s;
    logic                unused_wdata_s;

    assign go_wr_s        = bus.i_avs_write && (bus.i_avs_address == 3'd2);
    assign wr_acc_s       = bus.i_avs_write && !wait_s;
    assign launch_s       = (state_r == S_IDLE) && go_wr_s;
    assign unused_wdata_s = &{1'b0, bus.i_avs_writedata[31:X_W+Y_W]};

    // Sequencer state register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and waitrequest decode; a stall-mode GO is held from its first cycle.
    always_comb begin
        state_nxt_s = state_r;
        wait_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (go_wr_s) begin
                    state_nxt_s = S_LAUNCH;
                    wait_s      = ~mode_r;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_LAUNCH: begin
                wait_s      = stall_op_r;
                state_nxt_s = S_BUSY;
            end
            S_BUSY: begin
                wait_s = stall_op_r;
                if (bus.i_done) begin
                    state_nxt_s = stall_op_r ? S_RELEASE : S_IDLE;
                end else begin
                    state_nxt_s = S_BUSY;
                end
            end
            S_RELEASE: begin
                wait_s      = 1'b0;
                state_nxt_s = S_IDLE;
            end
            default: begin
                wait_s      = 1'b0;
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // User registers, active line snapshot, line counter and launch/busy flags.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mode_r      <= 1'b0;
            stall_op_r  <= 1'b0;
            start_r     <= 1'b0;
            busy_r      <= 1'b0;
            start_x_r   <= {X_W{1'b0}};
            start_y_r   <= {Y_W{1'b0}};
            end_x_r     <= {X_W{1'b0}};
            end_y_r     <= {Y_W{1'b0}};
            color_r     <= {COLOR_W{1'b0}};
            act_x0_r    <= {X_W{1'b0}};
            act_y0_r    <= {Y_W{1'b0}};
            act_x1_r    <= {X_W{1'b0}};
            act_y1_r    <= {Y_W{1'b0}};
            act_color_r <= {COLOR_W{1'b0}};
            lines_r     <= {CNT_W{1'b0}};
        end else begin
            if (wr_acc_s) begin
                case (bus.i_avs_address)
                    3'd0: mode_r <= bus.i_avs_writedata[0];
                    3'd3: {start_y_r, start_x_r} <= bus.i_avs_writedata[X_W+Y_W-1:0];
                    3'd4: {end_y_r, end_x_r}     <= bus.i_avs_writedata[X_W+Y_W-1:0];
                    3'd5: color_r <= bus.i_avs_writedata[COLOR_W-1:0];
                    default: mode_r <= mode_r;
                endcase
            end
            if (launch_s) begin
                act_x0_r    <= start_x_r;
                act_y0_r    <= start_y_r;
                act_x1_r    <= end_x_r;
                act_y1_r    <= end_y_r;
                act_color_r <= color_r;
                stall_op_r  <= ~mode_r;
            end
            // A clear wins over a same-cycle completion.
            if (wr_acc_s && (bus.i_avs_address == 3'd6)) begin
                lines_r <= {CNT_W{1'b0}};
            end else if ((state_r == S_BUSY) && bus.i_done) begin
                lines_r <= lines_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            start_r <= (state_nxt_s == S_LAUNCH);
            busy_r  <= (state_nxt_s == S_LAUNCH) || (state_nxt_s == S_BUSY);
        end
    end

    // Zero-wait-state register readback.
    always_comb begin
        rdata_s = 32'd0;
        if (bus.i_avs_read) begin
            case (bus.i_avs_address)
                3'd0: rdata_s[0] = mode_r;
                3'd1: rdata_s[0] = busy_r;
                3'd3: rdata_s[X_W+Y_W-1:0] = {start_y_r, start_x_r};
                3'd4: rdata_s[X_W+Y_W-1:0] = {end_y_r, end_x_r};
                3'd5: rdata_s[COLOR_W-1:0] = color_r;
                3'd6: rdata_s[CNT_W-1:0] = lines_r;
                default: rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign bus.o_avs_readdata    = rdata_s;
    assign bus.o_avs_waitrequest = wait_s;
    assign bus.o_start           = start_r;
    assign bus.o_busy            = busy_r;
    assign bus.o_x0              = act_x0_r;
    assign bus.o_y0              = act_y0_r;
    assign bus.o_x1              = act_x1_r;
    assign bus.o_y1              = act_y1_r;
    assign bus.o_color           = act_color_r;
endmodule

// File: tb/tb_lda_cmd_slave.sv
// Self-checking bench for lda_cmd_slave: register table, launch scoreboard and
// hand-written stall, busy-poll, counter and reset sequences.
module tb_lda_cmd_slave;
    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    typedef struct packed {
        logic [8:0] x0;
        logic [7:0] y0;
        logic [8:0] x1;
        logic [7:0] y1;
        logic [2:0] c;
    } launch_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passed = 0;
    launch_t exp_q[$];

    always #5 clk = ~clk;

    lda_cmd_slave_if bus();
    lda_cmd_slave_if bus2();

    lda_cmd_slave dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus));
    lda_cmd_slave #(.CNT_W(4)) dut2 (.i_clk(clk), .i_reset_n(rst_n), .bus(bus2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic launch_t mk(input int x0, input int y0, input int x1, input int y1, input int c);
        launch_t l;
        l.x0 = 9'(x0); l.y0 = 8'(y0); l.x1 = 9'(x1); l.y1 = 8'(y1); l.c = 3'(c);
        return l;
    endfunction

    // Scoreboard: every o_start must match the oldest pending launch.
    always @(negedge clk) begin
        if (bus.o_start === 1'b1) begin
            launch_t act;
            launch_t e;
            checks++;
            act = {bus.o_x0, bus.o_y0, bus.o_x1, bus.o_y1, bus.o_color};
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_start: got %h want no launch", act);
            end else begin
                e = exp_q.pop_front();
                if (act === e) passed++;
                else $display("FAIL launch: got %h want %h", act, e);
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.i_avs_address = a; bus.i_avs_writedata = d; bus.i_avs_write = 1'b1;
        @(negedge clk);
        bus.i_avs_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.i_avs_address = a; bus.i_avs_read = 1'b1;
        #1 d = bus.o_avs_readdata;
        bus.i_avs_read = 1'b0;
    endtask

    task automatic rdchk(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(name, d, exp);
    endtask

    task automatic done_after(input int n);
        repeat (n) @(negedge clk);
        bus.i_done = 1'b1;
        @(negedge clk);
        bus.i_done = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.o_busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'd0, bus.o_busy}, 32'd0);
    endtask

    initial begin
        vec_t tbl[$];
        int   bad;
        bus.i_avs_address = 3'd0; bus.i_avs_read = 1'b0; bus.i_avs_write = 1'b0;
        bus.i_avs_writedata = 32'd0; bus.i_done = 1'b0;
        bus2.i_avs_address = 3'd0; bus2.i_avs_read = 1'b0; bus2.i_avs_write = 1'b0;
        bus2.i_avs_writedata = 32'd0; bus2.i_done = 1'b0;

        for (int a = 0; a < 8; a++) tbl.push_back('{1'b0, 3'(a), 32'd0, 32'd0});
        tbl.push_back('{1'b1, 3'd0, 32'hFFFF_FFFF, 32'd0}); tbl.push_back('{1'b0, 3'd0, 32'd0, 32'd1});
        tbl.push_back('{1'b1, 3'd3, 32'hFFFF_FFFF, 32'd0}); tbl.push_back('{1'b0, 3'd3, 32'd0, 32'h0001_FFFF});
        tbl.push_back('{1'b1, 3'd5, 32'hFFFF_FFFF, 32'd0}); tbl.push_back('{1'b0, 3'd5, 32'd0, 32'd7});
        tbl.push_back('{1'b1, 3'd7, 32'hFFFF_FFFF, 32'd0}); tbl.push_back('{1'b0, 3'd7, 32'd0, 32'd0});
        tbl.push_back('{1'b1, 3'd1, 32'hFFFF_FFFF, 32'd0}); tbl.push_back('{1'b0, 3'd1, 32'd0, 32'd0});
        tbl.push_back('{1'b1, 3'd6, 32'hFFFF_FFFF, 32'd0}); tbl.push_back('{1'b0, 3'd6, 32'd0, 32'd0});
        tbl.push_back('{1'b1, 3'd3, 32'h0000_280A, 32'd0}); tbl.push_back('{1'b0, 3'd3, 32'd0, 32'h0000_280A});
        tbl.push_back('{1'b1, 3'd4, 32'h0000_6464, 32'd0}); tbl.push_back('{1'b0, 3'd4, 32'd0, 32'h0000_6464});
        tbl.push_back('{1'b1, 3'd5, 32'd5, 32'd0});         tbl.push_back('{1'b0, 3'd5, 32'd0, 32'd5});

        repeat (3) @(negedge clk);
        chk("reset_wait", {31'd0, bus.o_avs_waitrequest}, 32'd0);
        chk("reset_outs", {bus.o_start, bus.o_busy, bus.o_x0, bus.o_y0, bus.o_x1, bus.o_y1, bus.o_color}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
            else rdchk($sformatf("reg_a%0d_v%0d", tbl[i].addr, i), tbl[i].addr, tbl[i].exp);
        end

        // Poll-mode line.
        exp_q.push_back(mk(10, 20, 100, 50, 5));
        wr(3'd2, 32'd0);
        rdchk("poll_status_busy", 3'd1, 32'd1);
        done_after(6);
        rdchk("poll_status_idle", 3'd1, 32'd0);
        rdchk("poll_lines1", 3'd6, 32'd1);

        // Poll mode while busy: END write and GO must not disturb the active line.
        exp_q.push_back(mk(10, 20, 100, 50, 5));
        wr(3'd2, 32'd0);
        wr(3'd4, 32'd0);
        wr(3'd2, 32'd0);
        chk("busy_keep_x1", {23'd0, bus.o_x1}, 32'd100);
        chk("busy_keep_y1", {24'd0, bus.o_y1}, 32'd50);
        rdchk("busy_end_user", 3'd4, 32'd0);
        done_after(3);
        wait_idle();
        exp_q.push_back(mk(10, 20, 0, 0, 5));
        wr(3'd2, 32'd0);
        chk("next_go_x1y1", {15'd0, bus.o_x1, bus.o_y1}, 32'd0);
        done_after(3);
        wait_idle();
        rdchk("lines3", 3'd6, 32'd3);

        // Stall-mode GO held until the cycle after i_done.
        wr(3'd0, 32'd0);
        @(negedge clk);
        bus.i_avs_address = 3'd2; bus.i_avs_writedata = 32'd0; bus.i_avs_write = 1'b1;
        exp_q.push_back(mk(10, 20, 0, 0, 5));
        #1 chk("stall_same_cycle", {31'd0, bus.o_avs_waitrequest}, 32'd1);
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.o_avs_waitrequest !== 1'b1) bad++;
        end
        chk("stall_hold", 32'(bad), 32'd0);
        bus.i_done = 1'b1;
        @(negedge clk);
        bus.i_done = 1'b0;
        chk("stall_release", {30'd0, bus.o_avs_waitrequest, bus.o_busy}, 32'd0);
        @(posedge clk);
        #1 bus.i_avs_write = 1'b0;
        @(negedge clk);
        chk("stall_after", {30'd0, bus.o_avs_waitrequest, bus.o_busy}, 32'd0);
        rdchk("lines4", 3'd6, 32'd4);

        // LINES clear coinciding with a completion.
        wr(3'd0, 32'd1);
        exp_q.push_back(mk(10, 20, 0, 0, 5));
        wr(3'd2, 32'd0);
        @(negedge clk);
        bus.i_avs_address = 3'd6; bus.i_avs_write = 1'b1; bus.i_done = 1'b1;
        @(negedge clk);
        bus.i_avs_write = 1'b0; bus.i_done = 1'b0;
        rdchk("lines_clear_race", 3'd6, 32'd0);
        done_after(2);
        rdchk("done_in_idle", 3'd6, 32'd0);

        // GO in the same cycle as i_done is dropped.
        exp_q.push_back(mk(10, 20, 0, 0, 5));
        wr(3'd2, 32'd0);
        @(negedge clk);
        bus.i_avs_address = 3'd2; bus.i_avs_write = 1'b1; bus.i_done = 1'b1;
        @(negedge clk);
        bus.i_avs_write = 1'b0; bus.i_done = 1'b0;
        @(negedge clk);
        chk("go_with_done", {31'd0, bus.o_busy}, 32'd0);
        rdchk("lines_go_done", 3'd6, 32'd1);

        // Counter wrap on a 4-bit instance.
        @(negedge clk);
        bus2.i_avs_address = 3'd0; bus2.i_avs_writedata = 32'd1; bus2.i_avs_write = 1'b1;
        @(negedge clk);
        bus2.i_avs_write = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            bus2.i_avs_address = 3'd2; bus2.i_avs_write = 1'b1;
            @(negedge clk);
            bus2.i_avs_write = 1'b0;
            @(negedge clk);
            bus2.i_done = 1'b1;
            @(negedge clk);
            bus2.i_done = 1'b0;
            if (n >= 15) begin
                bus2.i_avs_address = 3'd6; bus2.i_avs_read = 1'b1;
                #1 chk($sformatf("wrap_lines_%0d", n), bus2.o_avs_readdata, (n == 15) ? 32'd15 : 32'd0);
                bus2.i_avs_read = 1'b0;
            end
        end

        // Reset in the middle of a stalled line.
        wr(3'd0, 32'd0);
        wr(3'd6, 32'd0);
        @(negedge clk);
        bus.i_avs_address = 3'd2; bus.i_avs_write = 1'b1;
        exp_q.push_back(mk(10, 20, 0, 0, 5));
        repeat (4) @(negedge clk);
        rst_n = 1'b0; bus.i_avs_write = 1'b0;
        #1 chk("rst_mid_wait_busy", {30'd0, bus.o_avs_waitrequest, bus.o_busy}, 32'd0);
        chk("rst_mid_active", {15'd0, bus.o_x0, bus.o_y0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_after(1);
        rdchk("rst_stray_lines", 3'd6, 32'd0);
        rdchk("rst_status", 3'd1, 32'd0);
        rdchk("rst_mode", 3'd0, 32'd0);
        rdchk("rst_start_reg", 3'd3, 32'd0);

        repeat (2) @(negedge clk);
        chk("launches_pending", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
